// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: derives round keys 0..10 and streams them ascending (encrypt) or descending (decrypt).
// Latency: first round key valid 10 edges after the key is accepted, then up to one key per cycle.
// Backpressure: roundkey/round_idx/rk_last hold while rk_valid && !rk_ready; key_ready only in IDLE.

// Forward AES S-box, computed as GF(2^8) inverse (x^254) followed by the affine transform.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] b;
        p = 8'h00;
        b = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ b;
            b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

    // Square-and-multiply chain: x^254 = x^240 * x^12 * x^2 (0 maps to 0)
    always_comb begin
        x2   = gmul(a, a);
        x3   = gmul(x2, a);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        inv  = gmul(gmul(x240, x12), x2);
    end

    assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_key_schedule #(
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0][3:0][7:0]  key_in,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic                  decrypt,
    output logic [3:0][3:0][7:0]  roundkey,
    output logic [3:0]            round_idx,
    output logic                  rk_last,
    output logic                  rk_valid,
    input  logic                  rk_ready
);
    localparam logic [3:0] LAST_IDX = NR[3:0];

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_STREAM} state_t;

    state_t                        state_q, state_d;
    logic [NR:0][3:0][3:0][7:0]    key_buf_q, key_buf_d;
    logic                          mode_q, mode_d;
    logic [3:0]                    cnt_q, cnt_d;
    logic [7:0]                    rcon_q, rcon_d;
    logic [3:0]                    ptr_q, ptr_d;
    logic                          key_ready_q, key_ready_d;
    logic                          rk_valid_q, rk_valid_d;
    logic                          rk_last_q, rk_last_d;

    logic [3:0][3:0][7:0]          prev_key;
    logic [3:0][3:0][7:0]          next_key;
    logic [3:0][7:0]               sub_w;
    logic [3:0][7:0]               t_w;

    // cnt stays in 1..NR, so cnt-1 always addresses a written entry
    assign prev_key = key_buf_q[cnt_q - 4'd1];

    // SubWord(RotWord(w3)): row r takes the byte from row r+1 of the last column
    for (genvar r = 0; r < 4; r++) begin : g_sbox
        aes_sbox u_sbox (
            .a (prev_key[(r + 1) % 4][3]),
            .s (sub_w[r])
        );
    end

    // One round of key expansion from the previous round key
    always_comb begin
        t_w      = sub_w;
        t_w[0]   = sub_w[0] ^ rcon_q;
        next_key = '0;
        for (int r = 0; r < 4; r++) begin
            next_key[r][0] = prev_key[r][0] ^ t_w[r];
            next_key[r][1] = prev_key[r][1] ^ next_key[r][0];
            next_key[r][2] = prev_key[r][2] ^ next_key[r][1];
            next_key[r][3] = prev_key[r][3] ^ next_key[r][2];
        end
    end

    // FSM next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        key_buf_d   = key_buf_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        rcon_d      = rcon_q;
        ptr_d       = ptr_q;
        key_ready_d = key_ready_q;
        rk_valid_d  = rk_valid_q;
        rk_last_d   = rk_last_q;
        case (state_q)
            S_IDLE: begin
                if (key_valid) begin
                    key_buf_d[0] = key_in;
                    mode_d       = decrypt;
                    cnt_d        = 4'd1;
                    rcon_d       = 8'h01;
                    key_ready_d  = 1'b0;
                    state_d      = S_EXPAND;
                end
            end
            S_EXPAND: begin
                key_buf_d[cnt_q] = next_key;
                rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                if (cnt_q == LAST_IDX) begin
                    state_d    = S_STREAM;
                    ptr_d      = mode_q ? LAST_IDX : 4'd0;
                    rk_valid_d = 1'b1;
                    rk_last_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_STREAM: begin
                if (rk_ready) begin
                    if (rk_last_q) begin
                        // pointer stays at the end key; no wrap past 0 or NR
                        state_d     = S_IDLE;
                        rk_valid_d  = 1'b0;
                        rk_last_d   = 1'b0;
                        key_ready_d = 1'b1;
                    end else if (mode_q) begin
                        ptr_d     = ptr_q - 4'd1;
                        rk_last_d = (ptr_q == 4'd1);
                    end else begin
                        ptr_d     = ptr_q + 4'd1;
                        rk_last_d = (ptr_q == LAST_IDX - 4'd1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any expansion or stream in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            key_buf_q   <= '0;
            mode_q      <= 1'b0;
            cnt_q       <= 4'd1;
            rcon_q      <= 8'h01;
            ptr_q       <= 4'd0;
            key_ready_q <= 1'b1;
            rk_valid_q  <= 1'b0;
            rk_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_buf_q   <= key_buf_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            rcon_q      <= rcon_d;
            ptr_q       <= ptr_d;
            key_ready_q <= key_ready_d;
            rk_valid_q  <= rk_valid_d;
            rk_last_q   <= rk_last_d;
        end
    end

    assign key_ready = key_ready_q;
    assign rk_valid  = rk_valid_q;
    assign rk_last   = rk_last_q;
    assign round_idx = ptr_q;
    assign roundkey  = key_buf_q[ptr_q];
endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: scoreboard of expected round keys per stream.
// Covers reset, encrypt/decrypt order, latency, backpressure hold, ignored keys, mid-stream reset.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_aes_key_schedule;
    logic                 clk = 1'b0;
    logic                 reset;
    logic [3:0][3:0][7:0] key_in;
    logic                 key_valid;
    logic                 key_ready;
    logic                 decrypt;
    logic [3:0][3:0][7:0] roundkey;
    logic [3:0]           round_idx;
    logic                 rk_last;
    logic                 rk_valid;
    logic                 rk_ready;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]   idx;
        logic         last;
        logic [127:0] key;
        bit           known;
    } exp_t;

    exp_t sb[$];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    // All-zero key: only round keys 0, 1 and 10 are checked in full
    localparam logic [127:0] ZERO_RK [11] = '{
        128'h0, 128'h62636363626363636263636362636363,
        128'h0, 128'h0, 128'h0, 128'h0, 128'h0, 128'h0, 128'h0, 128'h0,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e
    };
    localparam bit [10:0] ZERO_KNOWN = 11'b10000000011;

    aes_key_schedule #(.NR(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .decrypt   (decrypt),
        .roundkey  (roundkey),
        .round_idx (round_idx),
        .rk_last   (rk_last),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready)
    );

    always #5 clk = ~clk;

    // byte n of the key string sits at [n%4][n/4]
    function automatic logic [3:0][3:0][7:0] to_state(input logic [127:0] h);
        logic [3:0][3:0][7:0] s;
        s = '0;
        for (int n = 0; n < 16; n++) s[n % 4][n / 4] = h[127 - 8 * n -: 8];
        return s;
    endfunction

    function automatic logic [127:0] from_state(input logic [3:0][3:0][7:0] s);
        logic [127:0] h;
        h = '0;
        for (int n = 0; n < 16; n++) h[127 - 8 * n -: 8] = s[n % 4][n / 4];
        return h;
    endfunction

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Load one key and consume its stream.
    // stall_at: round index held off for 5 cycles; poke: drive ignored keys while busy;
    // abort_at: round index at which reset is pulsed (-1 = none)
    task automatic run_key(input logic [127:0] k, input bit dec, input bit zero_tab,
                           input int stall_at, input bit poke, input int abort_at);
        int   lat;
        int   cyc;
        int   xfers;
        int   stall_n;
        exp_t e;
        @(negedge clk);
        chk("key_ready_idle", key_ready, 1'b1);
        key_in    = to_state(k);
        decrypt   = dec;
        key_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            e.idx   = dec ? 4'(10 - i) : 4'(i);
            e.last  = (i == 10);
            e.key   = zero_tab ? ZERO_RK[e.idx] : FIPS_RK[e.idx];
            e.known = zero_tab ? ZERO_KNOWN[e.idx] : 1'b1;
            sb.push_back(e);
        end
        @(negedge clk);
        key_valid = 1'b0;
        key_in    = '0;
        decrypt   = ~dec;
        chk("busy_after_accept", key_ready, 1'b0);
        lat = 0;
        while (!rk_valid && lat < 50) begin
            key_valid = poke && (lat >= 2) && (lat < 5);
            @(negedge clk);
            lat++;
        end
        key_valid = 1'b0;
        chk("latency", lat, 10);
        stall_n = 0;
        xfers   = 0;
        cyc     = 0;
        while (sb.size() > 0 && cyc < 100) begin
            cyc++;
            if (abort_at == int'(sb[0].idx)) begin
                #2 reset = 1'b1;
                #1;
                chk("abort_valid", rk_valid, 1'b0);
                chk("abort_key_ready", key_ready, 1'b1);
                chk("abort_roundkey", from_state(roundkey), 128'h0);
                chk("abort_idx", round_idx, 4'd0);
                @(negedge clk);
                reset = 1'b0;
                sb.delete();
                rk_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("no_valid_after_abort", rk_valid, 1'b0);
                end
                return;
            end
            key_valid = poke && (xfers < 3);
            if (stall_at == int'(sb[0].idx) && stall_n < 5) begin
                rk_ready = 1'b0;
                stall_n++;
                chk("hold_valid", rk_valid, 1'b1);
                chk("hold_idx", round_idx, sb[0].idx);
                chk("hold_key", from_state(roundkey), sb[0].key);
            end else begin
                rk_ready = 1'b1;
                e = sb.pop_front();
                chk("stream_valid", rk_valid, 1'b1);
                chk("stream_idx", round_idx, e.idx);
                chk("stream_last", rk_last, e.last);
                if (e.known) chk("stream_key", from_state(roundkey), e.key);
                xfers++;
            end
            @(negedge clk);
        end
        key_valid = 1'b0;
        chk("transfer_count", xfers, 11);
        chk("valid_drops", rk_valid, 1'b0);
        chk("key_ready_back", key_ready, 1'b1);
        sb.delete();
    endtask

    initial begin
        reset     = 1'b0;
        key_valid = 1'b0;
        decrypt   = 1'b0;
        rk_ready  = 1'b1;
        key_in    = '0;
        // reset asserted between edges must take effect at once
        #3 reset = 1'b1;
        #1;
        chk("reset_key_ready", key_ready, 1'b1);
        chk("reset_valid", rk_valid, 1'b0);
        chk("reset_last", rk_last, 1'b0);
        chk("reset_roundkey", from_state(roundkey), 128'h0);
        chk("reset_idx", round_idx, 4'd0);
        @(negedge clk);
        reset = 1'b0;

        run_key(FIPS_KEY, 1'b0, 1'b0, -1, 1'b0, -1);   // encrypt order
        run_key(FIPS_KEY, 1'b1, 1'b0, -1, 1'b0, -1);   // decrypt order
        run_key(FIPS_KEY, 1'b0, 1'b0,  3, 1'b0, -1);   // backpressure at idx3
        run_key(FIPS_KEY, 1'b0, 1'b0, -1, 1'b1, -1);   // keys offered while busy
        run_key(FIPS_KEY, 1'b0, 1'b0, -1, 1'b0,  5);   // reset mid-stream
        run_key(128'h0,   1'b0, 1'b1, -1, 1'b0, -1);   // fresh all-zero key

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
